// File: rtl/jk_excitation_driver.sv
// Drives one cycle of J/K excitation per accepted target word for a bank of JK flip-flops.
// Define JK_DRIVER_CHECK_EN to compile in the CHECK state, which compares q_fb to the target.
module jk_excitation_driver #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          USE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_d, k_d;
  logic [WIDTH-1:0] exc_j, exc_k;
  logic             ready_d, done_d, err_d;

`ifndef JK_DRIVER_CHECK_EN
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
`endif

  // Excitation from the shadow state toward the offered word; only used on accept.
  assign exc_j = USE_TOGGLE ? (cur_q ^ tgt_data) : (tgt_data & ~cur_q);
  assign exc_k = USE_TOGGLE ? (cur_q ^ tgt_data) : (cur_q & ~tgt_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      tgt_q     <= '0;
      j         <= '0;
      k         <= '0;
      tgt_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      j         <= j_d;
      k         <= k_d;
      tgt_ready <= ready_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = err;
    case (state_q)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          state_d = DRIVE;
          tgt_d   = tgt_data;
          j_d     = exc_j;
          k_d     = exc_k;
          err_d   = 1'b0;
        end
      end
      DRIVE: begin
        cur_d = tgt_q;
`ifdef JK_DRIVER_CHECK_EN
        state_d = CHECK;
`else
        state_d = IDLE;
        done_d  = 1'b1;
`endif
      end
      CHECK: begin
        state_d = IDLE;
`ifdef JK_DRIVER_CHECK_EN
        done_d = 1'b1;
        // A bank that disagrees with the target becomes the new shadow state.
        if (q_fb != tgt_q) begin
          err_d = 1'b1;
          cur_d = q_fb;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: standard and toggle instances each drive a behavioural JK bank.
// Follows JK_DRIVER_CHECK_EN the same way the design does.
module tb_jk_excitation_driver;

  localparam int unsigned W = 4;
`ifdef JK_DRIVER_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tgt_valid;
  logic [W-1:0] tgt_data;
  logic         rdy0, rdy1, done0, done1, err0, err1;
  logic [W-1:0] j0, k0, j1, k1, bank0, bank1, q0, q1;
  logic         force_en;
  logic [W-1:0] force_val;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] m_cur;
  logic         m_err;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(W), .USE_TOGGLE(1'b0)) dut_std (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(rdy0), .j(j0), .k(k0), .q_fb(q0), .done(done0), .err(err0));

  jk_excitation_driver #(.WIDTH(W), .USE_TOGGLE(1'b1)) dut_tgl (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(rdy1), .j(j1), .k(k1), .q_fb(q1), .done(done1), .err(err1));

  // Behavioural JK banks; force_en models a bank that settles somewhere unexpected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (force_en) begin
      bank0 <= force_val;
      bank1 <= force_val;
    end else begin
      bank0 <= (j0 & ~bank0) | (~k0 & bank0);
      bank1 <= (j1 & ~bank1) | (~k1 & bank1);
    end
  end
  assign q0 = bank0;
  assign q1 = bank1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // JK excitation table, bit by bit.
  function automatic logic [2*W-1:0] excite(input logic [W-1:0] c, input logic [W-1:0] t,
                                            input bit toggle);
    logic [W-1:0] jj, kk;
    jj = '0;
    kk = '0;
    for (int i = 0; i < W; i++) begin
      if (toggle) begin
        if (c[i] != t[i]) begin jj[i] = 1'b1; kk[i] = 1'b1; end
      end else begin
        case ({c[i], t[i]})
          2'b01:   jj[i] = 1'b1;
          2'b10:   kk[i] = 1'b1;
          default: ;
        endcase
      end
    end
    return {jj, kk};
  endfunction

  task automatic chk_quiet(input string tag, input logic rdy, input logic dn, input logic er);
    chk({tag, "_j0"}, j0, '0);
    chk({tag, "_k0"}, k0, '0);
    chk({tag, "_j1"}, j1, '0);
    chk({tag, "_k1"}, k1, '0);
    chk({tag, "_rdy0"}, W'(rdy0), W'(rdy));
    chk({tag, "_rdy1"}, W'(rdy1), W'(rdy));
    chk({tag, "_done0"}, W'(done0), W'(dn));
    chk({tag, "_done1"}, W'(done1), W'(dn));
    chk({tag, "_err0"}, W'(err0), W'(er));
    chk({tag, "_err1"}, W'(err1), W'(er));
  endtask

  // Entry: #1 after an edge, in an IDLE cycle. Exit: #1 after the edge that starts the done cycle.
  task automatic txn(input logic [W-1:0] t, input bit do_force, input logic [W-1:0] fv,
                     input bit hold);
    logic [2*W-1:0] es, et;
    es = excite(m_cur, t, 1'b0);
    et = excite(m_cur, t, 1'b1);
    chk("ready_idle0", W'(rdy0), W'(1'b1));
    chk("ready_idle1", W'(rdy1), W'(1'b1));
    tgt_valid = 1'b1;
    tgt_data  = t;
    @(posedge clk); #1;
    if (!hold) tgt_valid = 1'b0;
    tgt_data = W'($urandom);
    chk("drive_j_std", j0, es[2*W-1:W]);
    chk("drive_k_std", k0, es[W-1:0]);
    chk("drive_j_tgl", j1, et[2*W-1:W]);
    chk("drive_k_tgl", k1, et[W-1:0]);
    chk("drive_rdy", W'(rdy0), '0);
    chk("drive_done", W'(done0), '0);
    chk("drive_err", W'(err0), '0);
`ifdef JK_DRIVER_CHECK_EN
    force_en  = do_force;
    force_val = fv;
    @(posedge clk); #1;
    force_en = 1'b0;
    chk("check_qfb", q0, do_force ? fv : t);
    chk_quiet("check", 1'b0, 1'b0, 1'b0);
`endif
    @(posedge clk); #1;
    m_err = CHECK_ON && do_force && (fv != t);
    m_cur = (CHECK_ON && do_force) ? fv : t;
    chk_quiet("done", 1'b1, 1'b1, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk_quiet("idle", 1'b1, 1'b0, m_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    force_en  = 1'b0;
    force_val = '0;
    m_cur     = '0;
    m_err     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_quiet("post_reset", 1'b1, 1'b0, 1'b0);

    txn(4'b1010, 1'b0, '0, 1'b0);
    idle(1);
    txn(4'b0110, 1'b0, '0, 1'b0);
    idle(1);
    txn(4'b0110, 1'b0, '0, 1'b0);
    idle(1);
`ifdef JK_DRIVER_CHECK_EN
    txn(4'b0110, 1'b1, 4'b0111, 1'b0);
    idle(2);
    txn(4'b0110, 1'b0, '0, 1'b0);
    idle(1);
`endif

    // Reset in the middle of DRIVE clears outputs at once and suppresses done.
    tgt_valid = 1'b1;
    tgt_data  = 4'b1100;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    chk("abort_j", j0, excite(m_cur, 4'b1100, 1'b0) >> W);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("abort_rst", 1'b0, 1'b0, 1'b0);
    m_cur = '0;
    m_err = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_quiet("abort_release", 1'b1, 1'b0, 1'b0);

    // Back-to-back accepts with valid held high.
    txn(4'b0001, 1'b0, '0, 1'b1);
    txn(4'b0011, 1'b0, '0, 1'b0);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] t, fv;
      bit hold, frc;
      t    = W'($urandom);
      fv   = W'($urandom);
      hold = 1'($urandom_range(0, 1));
      frc  = ($urandom_range(0, 3) == 0);
      txn(t, frc, fv, hold);
      if (!hold) idle($urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
